// File: rtl/vga_pkg.sv
// Shared VGA definitions: pixel format, framebuffer geometry and the linear
// address mapping used by the framebuffer and its clients.
package vga_pkg;

   typedef logic [7:0] pixel_t;

   localparam int FB_W        = 160;
   localparam int FB_H        = 120;
   localparam int SCALE_SHIFT = 2;
   localparam int ADDR_W      = 15;

   localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_W * FB_H - 1);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      DONE
   } fbState_t;

   // Row stride of 160 is built from two shifts so no multiplier is needed.
   function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [7:0] y);
      logic [ADDR_W-1:0] yy;
      yy = ADDR_W'(y);
      return (yy << 7) + (yy << 5) + ADDR_W'(x);
   endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port pixel RAM: one write port, one synchronous read port.
// Read-first behaviour on a same-address collision; contents are never reset.
module fb_ram #(
   parameter int AW = 15,
   parameter int DW = 8
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clock) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/vga_framebuffer.sv
// 160x120 RRRGGGBB framebuffer feeding vga_driver, with a CPU write port and a
// hardware clear engine that fills the whole image with one colour.
module vga_framebuffer
   import vga_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [9:0] next_x,
   input  logic [9:0] next_y,
   output pixel_t     color_out,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [7:0] wr_x,
   input  logic [6:0] wr_y,
   input  pixel_t     wr_color,
   input  logic       clr_start,
   input  pixel_t     clr_color,
   output logic       busy,
   output logic       clr_done
);

   logic [7:0]        rdCol;
   logic [7:0]        rdRow;
   logic              rdInRange;
   logic [ADDR_W-1:0] rdAddr;
   logic              blank_q;

   logic              wrInRange;
   logic              wrFire;

   fbState_t          state_q, state_d;
   logic [ADDR_W-1:0] count_q, count_d;
   pixel_t            fill_q, fill_d;
   logic              wrReady_q;
   logic              busy_q;
   logic              done_q;

   logic              ramWe;
   logic [ADDR_W-1:0] ramWaddr;
   pixel_t            ramWdata;
   pixel_t            ramRdata;

   assign rdCol     = 8'(next_x >> SCALE_SHIFT);
   assign rdRow     = 8'(next_y >> SCALE_SHIFT);
   assign rdInRange = (rdCol < 8'(FB_W)) && (rdRow < 8'(FB_H));
   assign rdAddr    = fb_addr(rdCol, rdRow);

   assign wrInRange = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
   assign wrFire    = wr_valid & wrReady_q;

   // Clear engine owns the write port while active; wr_ready keeps the CPU out.
   assign ramWe    = ~reset & ((state_q == CLEAR) | (wrFire & wrInRange));
   assign ramWaddr = (state_q == CLEAR) ? count_q : fb_addr(wr_x, {1'b0, wr_y});
   assign ramWdata = (state_q == CLEAR) ? fill_q : wr_color;

   fb_ram #(
      .AW(ADDR_W),
      .DW(8)
   ) u_ram (
      .clock(clock),
      .we   (ramWe),
      .waddr(ramWaddr),
      .wdata(ramWdata),
      .raddr(rdAddr),
      .rdata(ramRdata)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      fill_d  = fill_q;
      case (state_q)
         IDLE: begin
            if (clr_start) begin
               fill_d  = clr_color;
               count_d = '0;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            count_d = count_q + 1'b1;
            if (count_q == FB_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         fill_q    <= '0;
         wrReady_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         blank_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         fill_q    <= fill_d;
         wrReady_q <= (state_d == IDLE);
         busy_q    <= (state_d == CLEAR);
         done_q    <= (state_d == DONE);
         blank_q   <= ~rdInRange;
      end
   end

   assign color_out = blank_q ? '0 : ramRdata;
   assign wr_ready  = wrReady_q;
   assign busy      = busy_q;
   assign clr_done  = done_q;

endmodule

// File: tb/tb_vga_framebuffer.sv
// Directed bench for vga_framebuffer: read requests push expected colours into
// a scoreboard queue that a separate monitor drains one cycle later.
module tb_vga_framebuffer;
   import vga_pkg::*;

   logic       clock;
   logic       reset;
   logic [9:0] next_x;
   logic [9:0] next_y;
   pixel_t     color_out;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_x;
   logic [6:0] wr_y;
   pixel_t     wr_color;
   logic       clr_start;
   pixel_t     clr_color;
   logic       busy;
   logic       clr_done;

   typedef struct {
      int     sx;
      int     sy;
      pixel_t color;
   } rdExp_t;

   rdExp_t expQ[$];
   logic   readReq;
   int     checks;
   int     errors;

   vga_framebuffer dut (
      .clock    (clock),
      .reset    (reset),
      .next_x   (next_x),
      .next_y   (next_y),
      .color_out(color_out),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_x     (wr_x),
      .wr_y     (wr_y),
      .wr_color (wr_color),
      .clr_start(clr_start),
      .clr_color(clr_color),
      .busy     (busy),
      .clr_done (clr_done)
   );

   initial clock = 1'b0;
   always #20 clock = ~clock;

   // Global time limit so a stuck design still ends the run.
   initial begin
      #(40 * 90000);
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Monitor: every sampled read request yields one colour one cycle later.
   always @(posedge clock) begin : monitor
      rdExp_t e;
      if (readReq === 1'b1) begin
         #1;
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL color_out: got %h but no expected entry queued", color_out);
         end else begin
            e = expQ.pop_front();
            if (color_out !== e.color) begin
               errors++;
               $display("[TB] FAIL color_out(%0d,%0d): got %h expected %h", e.sx, e.sy, color_out, e.color);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int sx, input int sy, input pixel_t exp);
      rdExp_t e;
      @(negedge clock);
      next_x  = 10'(sx);
      next_y  = 10'(sy);
      e.sx    = sx;
      e.sy    = sy;
      e.color = exp;
      expQ.push_back(e);
      readReq = 1'b1;
      @(negedge clock);
      readReq = 1'b0;
   endtask

   task automatic doWrite(input logic [7:0] x, input logic [6:0] y, input pixel_t c);
      @(negedge clock);
      wr_valid = 1'b1;
      wr_x     = x;
      wr_y     = y;
      wr_color = c;
      checkOutput("wr_ready_at_write", 32'(wr_ready), 32'd1);
      @(negedge clock);
      wr_valid = 1'b0;
   endtask

   // Called on the negedge of the first CLEAR cycle; optionally pulses a
   // second clr_start mid-fill, which the design must ignore.
   task automatic waitClear(input int injectAt);
      int n;
      bit wrSeen;
      n      = 0;
      wrSeen = 1'b0;
      while (busy === 1'b1 && n < 20000) begin
         if (wr_ready !== 1'b0) wrSeen = 1'b1;
         if (n == injectAt) begin
            clr_start = 1'b1;
            clr_color = 8'hFF;
         end else begin
            clr_start = 1'b0;
         end
         n++;
         @(negedge clock);
      end
      clr_start = 1'b0;
      checkOutput("busy_cycles", 32'(n), 32'd19200);
      checkOutput("wr_ready_during_clear", 32'(wrSeen), 32'd0);
      checkOutput("clr_done_pulse", 32'(clr_done), 32'd1);
      checkOutput("busy_after_clear", 32'(busy), 32'd0);
      @(negedge clock);
      checkOutput("clr_done_width", 32'(clr_done), 32'd0);
      checkOutput("wr_ready_after_clear", 32'(wr_ready), 32'd1);
   endtask

   initial begin : stimulus
      int doneSeen;
      checks    = 0;
      errors    = 0;
      readReq   = 1'b0;
      reset     = 1'b1;
      next_x    = '0;
      next_y    = '0;
      wr_valid  = 1'b0;
      wr_x      = '0;
      wr_y      = '0;
      wr_color  = '0;
      clr_start = 1'b0;
      clr_color = '0;

      // Reset behaviour
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("reset_color_out", 32'(color_out), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_clr_done", 32'(clr_done), 32'd0);
      checkOutput("reset_wr_ready", 32'(wr_ready), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("wr_ready_after_reset", 32'(wr_ready), 32'd1);
      checkOutput("busy_after_reset", 32'(busy), 32'd0);
      checkOutput("clr_done_after_reset", 32'(clr_done), 32'd0);

      // Single pixel write covers a 4x4 screen block
      doWrite(8'd6, 7'd3, 8'h55);
      doWrite(8'd5, 7'd3, 8'hE0);
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < 4; i++) begin
            applyStimulus(20 + i, 12 + j, 8'hE0);
         end
      end
      applyStimulus(24, 12, 8'h55);
      applyStimulus(24, 15, 8'h55);
      applyStimulus(640, 0, 8'h00);
      applyStimulus(0, 480, 8'h00);
      applyStimulus(1023, 1023, 8'h00);

      // Full clear, with an ignored restart request in the middle
      @(negedge clock);
      clr_color = 8'h1C;
      clr_start = 1'b1;
      @(negedge clock);
      clr_start = 1'b0;
      waitClear(50);
      applyStimulus(636, 476, 8'h1C);
      applyStimulus(20, 12, 8'h1C);
      applyStimulus(0, 0, 8'h1C);

      // Write and clear requested in the same idle cycle
      @(negedge clock);
      wr_valid  = 1'b1;
      wr_x      = 8'd0;
      wr_y      = 7'd0;
      wr_color  = 8'hFF;
      clr_color = 8'h03;
      clr_start = 1'b1;
      checkOutput("wr_ready_with_clr_start", 32'(wr_ready), 32'd1);
      @(negedge clock);
      wr_valid  = 1'b0;
      clr_start = 1'b0;
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      checkOutput("wr_ready_after_start", 32'(wr_ready), 32'd0);
      waitClear(-1);
      applyStimulus(0, 0, 8'h03);

      // Out-of-range write is consumed but dropped
      doWrite(8'd160, 7'd0, 8'hAA);
      applyStimulus(0, 4, 8'h03);
      applyStimulus(639, 479, 8'h03);
      applyStimulus(636, 0, 8'h03);

      // Reset during CLEAR cycle 100
      @(negedge clock);
      clr_color = 8'h5A;
      clr_start = 1'b1;
      @(negedge clock);
      clr_start = 1'b0;
      checkOutput("busy_clear_cycle0", 32'(busy), 32'd1);
      repeat (100) @(negedge clock);
      checkOutput("busy_clear_cycle100", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("busy_after_midreset", 32'(busy), 32'd0);
      checkOutput("clr_done_after_midreset", 32'(clr_done), 32'd0);
      reset    = 1'b0;
      doneSeen = 0;
      repeat (4) begin
         @(negedge clock);
         if (clr_done !== 1'b0) doneSeen++;
      end
      checkOutput("no_clr_done_after_midreset", 32'(doneSeen), 32'd0);
      checkOutput("busy_idle_after_midreset", 32'(busy), 32'd0);
      applyStimulus(0, 0, 8'h5A);
      applyStimulus(396, 0, 8'h5A);
      applyStimulus(400, 0, 8'h03);
      applyStimulus(636, 0, 8'h03);
      applyStimulus(0, 4, 8'h03);
      applyStimulus(636, 476, 8'h03);

      // A fresh clear after the aborted one runs to completion
      @(negedge clock);
      clr_color = 8'h3C;
      clr_start = 1'b1;
      @(negedge clock);
      clr_start = 1'b0;
      waitClear(-1);
      applyStimulus(400, 0, 8'h3C);
      applyStimulus(636, 476, 8'h3C);

      repeat (3) @(negedge clock);
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
